// File: rtl/machine_timer.sv
// RISC-V machine timer: 64-bit mtime/mtimecmp behind a 5-word register window, with a prescaler.
// Optional TIMER_PERIODIC_EN makes ctrl.PERIODIC writable, so mtime reloads to 0 on a compare match.
module machine_timer #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] BASE_ADDR = 32'h0000_0400
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] clk_rate,
    input  logic [WIDTH-1:0] addr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             wr_en,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rdata,
    output logic [WIDTH-1:0] timer_interrupt
);
    localparam int TW = 2 * WIDTH;

    localparam logic [WIDTH-1:0] A_MLO  = BASE_ADDR;
    localparam logic [WIDTH-1:0] A_MHI  = BASE_ADDR + WIDTH'(4);
    localparam logic [WIDTH-1:0] A_CLO  = BASE_ADDR + WIDTH'(8);
    localparam logic [WIDTH-1:0] A_CHI  = BASE_ADDR + WIDTH'(12);
    localparam logic [WIDTH-1:0] A_CTRL = BASE_ADDR + WIDTH'(16);

    logic [TW-1:0]    mtime, mtimecmp;
    logic [WIDTH-1:0] prescaler, limit, rd_mux;
    logic             en, periodic, mtip, tick, reload, match, ge;
    logic             hit_mlo, hit_mhi, hit_clo, hit_chi, hit_ctrl;
    logic             wr_mlo, wr_mhi, wr_clo, wr_chi, wr_ctrl;

    // Exact-address compares give alignment and range checking for free.
    assign hit_mlo  = (addr == A_MLO);
    assign hit_mhi  = (addr == A_MHI);
    assign hit_clo  = (addr == A_CLO);
    assign hit_chi  = (addr == A_CHI);
    assign hit_ctrl = (addr == A_CTRL);

    assign wr_mlo  = wr_en && hit_mlo;
    assign wr_mhi  = wr_en && hit_mhi;
    assign wr_clo  = wr_en && hit_clo;
    assign wr_chi  = wr_en && hit_chi;
    assign wr_ctrl = wr_en && hit_ctrl;

    assign limit  = (clk_rate == '0) ? '0 : clk_rate - WIDTH'(1);
    assign tick   = en && (prescaler == limit);
    assign match  = (mtime == mtimecmp);
    assign ge     = (mtime >= mtimecmp);
    assign reload = periodic && match;

    // A count above limit (clk_rate just shrank) wraps to 0 without ticking.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            prescaler <= '0;
        else if (wr_mlo || wr_mhi)
            prescaler <= '0;
        else if (en)
            prescaler <= (prescaler >= limit) ? '0 : prescaler + WIDTH'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            mtime <= '0;
        else if (wr_mlo)
            mtime[WIDTH-1:0] <= wdata;
        else if (wr_mhi)
            mtime[TW-1:WIDTH] <= wdata;
        else if (tick)
            mtime <= reload ? '0 : mtime + TW'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mtimecmp <= '1;
            en       <= 1'b0;
        end else begin
            if (wr_clo)  mtimecmp[WIDTH-1:0]  <= wdata;
            if (wr_chi)  mtimecmp[TW-1:WIDTH] <= wdata;
            if (wr_ctrl) en <= wdata[0];
        end
    end

`ifdef TIMER_PERIODIC_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            periodic <= 1'b0;
        else if (wr_ctrl)
            periodic <= wdata[1];
    end
`else
    assign periodic = 1'b0;
`endif

    // In periodic mode mtime never legitimately exceeds mtimecmp, so only equality raises MTIP.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            mtip <= 1'b0;
        else
            mtip <= periodic ? match : ge;
    end

    assign timer_interrupt = mtip ? WIDTH'(32'h0000_0080) : '0;

    always_comb begin
        rd_mux = '0;
        if (hit_mlo)  rd_mux = mtime[WIDTH-1:0];
        if (hit_mhi)  rd_mux = mtime[TW-1:WIDTH];
        if (hit_clo)  rd_mux = mtimecmp[WIDTH-1:0];
        if (hit_chi)  rd_mux = mtimecmp[TW-1:WIDTH];
        if (hit_ctrl) rd_mux = {{(WIDTH-2){1'b0}}, periodic, en};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            rdata <= '0;
        else if (rd_en)
            rdata <= rd_mux;
    end
endmodule

// File: tb/tb_machine_timer.sv
// Directed bench for machine_timer: reset, prescale, compare, carry/wrap, collisions, periodic mode.
module tb_machine_timer;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] clk_rate, addr, wdata, rdata, timer_interrupt;
    logic        wr_en, rd_en;
    int          total = 0;
    int          passes = 0;

    localparam logic [31:0] B    = 32'h0000_0400;
    localparam logic [31:0] MLO  = B;
    localparam logic [31:0] MHI  = B + 32'h4;
    localparam logic [31:0] CLO  = B + 32'h8;
    localparam logic [31:0] CHI  = B + 32'hC;
    localparam logic [31:0] CTRL = B + 32'h10;
    localparam logic [31:0] IRQ  = 32'h0000_0080;

    machine_timer #(.WIDTH(32), .BASE_ADDR(B)) dut (
        .clk(clk), .reset(reset), .clk_rate(clk_rate), .addr(addr), .wdata(wdata),
        .wr_en(wr_en), .rd_en(rd_en), .rdata(rdata), .timer_interrupt(timer_interrupt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passes++;
        else $error("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        addr = a; wdata = d; wr_en = 1'b1;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic rdchk(input string tag, input logic [31:0] a, input logic [31:0] exp);
        addr = a; rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        chk(tag, rdata, exp);
    endtask

    initial begin
        reset = 1'b0; clk_rate = '0; addr = '0; wdata = '0; wr_en = 1'b0; rd_en = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_irq", timer_interrupt, 32'h0);
        reset = 1'b1;
        @(negedge clk);
        chk("post_rst_irq", timer_interrupt, 32'h0);
        rdchk("rst_mlo", MLO, 32'h0);
        rdchk("rst_mhi", MHI, 32'h0);
        rdchk("rst_clo", CLO, 32'hFFFF_FFFF);
        rdchk("rst_chi", CHI, 32'hFFFF_FFFF);
        rdchk("rst_ctrl", CTRL, 32'h0);
        rdchk("oob_read", B + 32'h14, 32'h0);
        rdchk("misaligned_read", B + 32'h2, 32'h0);
        wr(B + 32'h2, 32'h1234);
        wr(B + 32'h14, 32'h1);
        rdchk("ignored_wr_mlo", MLO, 32'h0);
        rdchk("ignored_wr_ctrl", CTRL, 32'h0);

        // Prescale by 4: ticks land on the 4th, 8th, ... cycle after enable.
        clk_rate = 32'd4;
        wr(CTRL, 32'h1);
        repeat (3) @(negedge clk);
        rdchk("pre_tick4", MLO, 32'd0);
        rdchk("tick4", MLO, 32'd1);
        repeat (2) @(negedge clk);
        rdchk("pre_tick8", MLO, 32'd1);
        rdchk("tick8", MLO, 32'd2);
        repeat (30) @(negedge clk);
        rdchk("cyc40_pre", MLO, 32'd9);
        rdchk("cyc40", MLO, 32'd10);
        wr(CTRL, 32'h0);
        clk_rate = 32'd0;
        wr(MLO, 32'h0);
        wr(CTRL, 32'h1);
        repeat (40) @(negedge clk);
        rdchk("rate0_lo", MLO, 32'd40);
        rdchk("rate0_hi", MHI, 32'd0);
        wr(CTRL, 32'h0);

        // Compare.
        clk_rate = 32'd1;
        wr(MLO, 32'h0);
        wr(CHI, 32'h0);
        wr(CLO, 32'd5);
        wr(CTRL, 32'h1);
        repeat (5) @(negedge clk);
        chk("cmp_at5", timer_interrupt, 32'h0);
        @(negedge clk);
        chk("cmp_hit", timer_interrupt, IRQ);
        wr(CLO, 32'd100);
        chk("cmp_raise_same", timer_interrupt, IRQ);
        @(negedge clk);
        chk("cmp_raise_clr", timer_interrupt, 32'h0);
        wr(CTRL, 32'h0);

        // Carry and 64-bit wrap: enable then disable gives exactly one tick.
        wr(MLO, 32'hFFFF_FFFF);
        wr(MHI, 32'h0);
        wr(CTRL, 32'h1);
        wr(CTRL, 32'h0);
        rdchk("carry_hi", MHI, 32'd1);
        rdchk("carry_lo", MLO, 32'd0);
        wr(MLO, 32'hFFFF_FFFF);
        wr(MHI, 32'hFFFF_FFFF);
        chk("max_irq", timer_interrupt, IRQ);
        wr(CLO, 32'hFFFF_FFFF);
        wr(CHI, 32'hFFFF_FFFF);
        @(negedge clk);
        chk("eq_max_irq", timer_interrupt, IRQ);
        wr(CTRL, 32'h1);
        wr(CTRL, 32'h0);
        rdchk("wrap_lo", MLO, 32'd0);
        rdchk("wrap_hi", MHI, 32'd0);
        chk("wrap_irq", timer_interrupt, 32'h0);

        // Store colliding with a tick, then a store that restarts the prescaler.
        clk_rate = 32'd4;
        wr(MLO, 32'h0);
        wr(CTRL, 32'h1);
        repeat (3) @(negedge clk);
        wr(MLO, 32'h55);
        repeat (2) @(negedge clk);
        rdchk("coll_val", MLO, 32'h55);
        rdchk("coll_pre_tick", MLO, 32'h55);
        rdchk("coll_tick", MLO, 32'h56);
        wr(MLO, 32'h10);
        repeat (2) @(negedge clk);
        rdchk("psc_clr_a", MLO, 32'h10);
        rdchk("psc_clr_b", MLO, 32'h10);
        rdchk("psc_clr_tick", MLO, 32'h11);
        wr(CTRL, 32'h0);
        addr = CLO; wdata = 32'h1234; wr_en = 1'b1; rd_en = 1'b1;
        @(negedge clk);
        wr_en = 1'b0; rd_en = 1'b0;
        chk("rw_old", rdata, 32'hFFFF_FFFF);
        repeat (3) @(negedge clk);
        chk("rdata_hold", rdata, 32'hFFFF_FFFF);
        rdchk("rw_new", CLO, 32'h1234);

        // Periodic mode (free-running when the option is absent).
        clk_rate = 32'd1;
        wr(MLO, 32'h0);
        wr(MHI, 32'h0);
        wr(CHI, 32'h0);
        wr(CLO, 32'd3);
        wr(CTRL, 32'h3);
        for (int k = 1; k <= 8; k++) begin
`ifdef TIMER_PERIODIC_EN
            rdchk($sformatf("per_mtime%0d", k), MLO, 32'((k - 1) % 4));
            chk($sformatf("per_irq%0d", k), timer_interrupt, (k % 4 == 0) ? IRQ : 32'h0);
`else
            rdchk($sformatf("free_mtime%0d", k), MLO, 32'(k - 1));
            chk($sformatf("free_irq%0d", k), timer_interrupt, (k >= 4) ? IRQ : 32'h0);
`endif
        end
`ifdef TIMER_PERIODIC_EN
        rdchk("ctrl_rd", CTRL, 32'h3);
`else
        rdchk("ctrl_rd", CTRL, 32'h1);
`endif
        wr(CTRL, 32'h0);

        // clk_rate shrinks below the running count: wrap with no tick.
        wr(MLO, 32'h0);
        wr(MHI, 32'h0);
        clk_rate = 32'd8;
        wr(CTRL, 32'h1);
        repeat (5) @(negedge clk);
        clk_rate = 32'd2;
        repeat (2) @(negedge clk);
        rdchk("shrink_pre", MLO, 32'd0);
        rdchk("shrink_tick", MLO, 32'd1);

        // Asynchronous reset mid-count with MTIP pending.
        wr(CLO, 32'h0);
        rdchk("pre_rst_ctrl", CTRL, 32'h1);
        chk("pre_rst_irq", timer_interrupt, IRQ);
        #2 reset = 1'b0;
        #1;
        chk("async_rst_rdata", rdata, 32'h0);
        chk("async_rst_irq", timer_interrupt, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        rdchk("rst2_mlo", MLO, 32'h0);
        rdchk("rst2_clo", CLO, 32'hFFFF_FFFF);
        rdchk("rst2_ctrl", CTRL, 32'h0);
        chk("rst2_irq", timer_interrupt, 32'h0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
